// File: rtl/booth_mpy_pkg.sv
// Shared types for the iterative radix-4 Booth multiplier: FSM states,
// Booth digit codes and the digit-count helper.
package booth_mpy_pkg;

  typedef enum logic [1:0] {IDLE, CALC, DONE} state_t;

  typedef enum logic [2:0] {ZERO, POS1, POS2, NEG1, NEG2} booth_dig_t;

  // Radix-4 digits over the (width+2)-bit extended multiplier.
  function automatic int booth_ndig(input int width);
    return (width + 2) / 2;
  endfunction

endpackage

// File: rtl/booth_r4_enc.sv
// Radix-4 Booth digit encoder: turns a multiplier triplet into a partial
// product of a_ext; negative digits come out inverted with neg as carry-in.
module booth_r4_enc
  import booth_mpy_pkg::*;
#(
  parameter int WIDTH = 32
) (
  input  logic [2:0]       trip,
  input  logic [WIDTH+1:0] a_ext,
  output logic [WIDTH+3:0] pp,
  output logic             neg
);

  booth_dig_t       dig;
  logic [WIDTH+3:0] mag;

  always_comb begin
    dig = ZERO;
    case (trip)
      3'b001, 3'b010: dig = POS1;
      3'b011:         dig = POS2;
      3'b100:         dig = NEG2;
      3'b101, 3'b110: dig = NEG1;
      default:        dig = ZERO;
    endcase

    mag = '0;
    case (dig)
      POS1, NEG1: mag = {{2{a_ext[WIDTH+1]}}, a_ext};
      POS2, NEG2: mag = {a_ext[WIDTH+1], a_ext, 1'b0};
      default:    mag = '0;
    endcase

    neg = (dig == NEG1) || (dig == NEG2);
    pp  = neg ? ~mag : mag;
  end

endmodule

// File: rtl/booth_mpy_seq.sv
// Iterative radix-4 Booth multiplier: one digit per clock, signed/unsigned
// per operation, valid/ready on both sides.
module booth_mpy_seq
  import booth_mpy_pkg::*;
#(
  parameter int WIDTH = 32
) (
  input  logic               clk,
  input  logic               rst_n,
  input  logic               in_valid,
  output logic               in_ready,
  input  logic [WIDTH-1:0]   a,
  input  logic [WIDTH-1:0]   b,
  input  logic               is_signed,
  output logic               out_valid,
  input  logic               out_ready,
  output logic [2*WIDTH-1:0] p
);

  localparam int NDIG = booth_ndig(WIDTH);
  localparam int CW   = $clog2(NDIG + 1);

  state_t           state_q, state_d;
  logic [WIDTH+3:0] acc_q;
  logic [WIDTH+1:0] mul_q;
  logic             prev_q;
  logic [WIDTH+1:0] a_q;
  logic [CW-1:0]    cnt_q;
  logic [2*WIDTH-1:0] p_q;

  logic [WIDTH+3:0] pp, sum, acc_sh;
  logic [WIDTH+1:0] mul_sh;
  logic             neg, last;

  booth_r4_enc #(.WIDTH(WIDTH)) u_enc (
    .trip  ({mul_q[1:0], prev_q}),
    .a_ext (a_q),
    .pp    (pp),
    .neg   (neg)
  );

  // Accumulator and multiplier shift together as one (2*WIDTH+6)-bit word.
  assign sum    = acc_q + pp + {{(WIDTH+3){1'b0}}, neg};
  assign acc_sh = {{2{sum[WIDTH+3]}}, sum[WIDTH+3:2]};
  assign mul_sh = {sum[1:0], mul_q[WIDTH+1:2]};
  assign last   = (cnt_q == CW'(NDIG - 1));

  always_comb begin
    state_d = state_q;
    case (state_q)
      IDLE:    if (in_valid) state_d = CALC;
      CALC:    if (last)     state_d = DONE;
      DONE:    if (out_ready) state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state_q <= IDLE;
    else        state_q <= state_d;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      acc_q  <= '0;
      mul_q  <= '0;
      prev_q <= 1'b0;
      a_q    <= '0;
      cnt_q  <= '0;
      p_q    <= '0;
    end else if (state_q == IDLE && in_valid) begin
      acc_q  <= '0;
      mul_q  <= is_signed ? {{2{b[WIDTH-1]}}, b} : {2'b00, b};
      a_q    <= is_signed ? {{2{a[WIDTH-1]}}, a} : {2'b00, a};
      prev_q <= 1'b0;
      cnt_q  <= '0;
    end else if (state_q == CALC) begin
      acc_q  <= acc_sh;
      mul_q  <= mul_sh;
      prev_q <= mul_q[1];
      cnt_q  <= cnt_q + CW'(1);
      if (last) p_q <= {acc_sh[WIDTH-3:0], mul_sh};
    end
  end

  assign in_ready  = (state_q == IDLE);
  assign out_valid = (state_q == DONE);
  assign p         = p_q;

endmodule

// File: tb/tb_booth_mpy_seq.sv
// Bench for booth_mpy_seq: constant vector table and corner sequences at
// WIDTH=32, plus random/corner sweeps at WIDTH=8 against an arithmetic model.
module tb_booth_mpy_seq;

  logic clk = 1'b0;
  logic rst_n;
  always #5 clk = ~clk;

  logic        iv32, ir32, s32, ov32, or32;
  logic [31:0] a32, b32;
  logic [63:0] p32;
  logic        iv8, ir8, s8, ov8, or8;
  logic [7:0]  a8, b8;
  logic [15:0] p8;

  booth_mpy_seq #(.WIDTH(32)) dut32 (
    .clk(clk), .rst_n(rst_n), .in_valid(iv32), .in_ready(ir32), .a(a32), .b(b32),
    .is_signed(s32), .out_valid(ov32), .out_ready(or32), .p(p32)
  );

  booth_mpy_seq #(.WIDTH(8)) dut8 (
    .clk(clk), .rst_n(rst_n), .in_valid(iv8), .in_ready(ir8), .a(a8), .b(b8),
    .is_signed(s8), .out_valid(ov8), .out_ready(or8), .p(p8)
  );

  int passed = 0;
  int total  = 0;

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    total++;
    if (act === exp) passed++;
    else $display("FAIL %s: got %h expected %h", name, act, exp);
  endtask

  function automatic logic [63:0] ref32(input logic [31:0] a, input logic [31:0] b, input logic s);
    longint sa, sb;
    if (s) begin
      sa = longint'($signed(a));
      sb = longint'($signed(b));
      return 64'(sa * sb);
    end
    return {32'b0, a} * {32'b0, b};
  endfunction

  function automatic logic [15:0] ref8(input logic [7:0] a, input logic [7:0] b, input logic s);
    int sa, sb;
    if (s) begin
      sa = int'($signed(a));
      sb = int'($signed(b));
      return 16'(sa * sb);
    end
    return {8'b0, a} * {8'b0, b};
  endfunction

  // Called #1 after a rising edge; returns product and accept-to-valid latency.
  task automatic run32(input logic [31:0] a, input logic [31:0] b, input logic s,
                       output logic [63:0] p, output int lat);
    int guard = 0;
    while (!ir32 && guard < 50) begin @(posedge clk); #1; guard++; end
    a32 = a; b32 = b; s32 = s; iv32 = 1'b1;
    @(posedge clk); #1;
    iv32 = 1'b0;
    lat = 0;
    while (!ov32 && lat < 100) begin @(posedge clk); #1; lat++; end
    p = p32;
    or32 = 1'b1;
    @(posedge clk); #1;
    or32 = 1'b0;
  endtask

  task automatic run8(input logic [7:0] a, input logic [7:0] b, input logic s,
                      output logic [15:0] p, output int lat);
    int guard = 0;
    while (!ir8 && guard < 50) begin @(posedge clk); #1; guard++; end
    a8 = a; b8 = b; s8 = s; iv8 = 1'b1;
    @(posedge clk); #1;
    iv8 = 1'b0;
    lat = 0;
    while (!ov8 && lat < 50) begin @(posedge clk); #1; lat++; end
    p = p8;
    or8 = 1'b1;
    @(posedge clk); #1;
    or8 = 1'b0;
  endtask

  typedef struct {
    logic [31:0] a;
    logic [31:0] b;
    logic        s;
    logic [63:0] exp;
  } vec_t;

  initial begin
    vec_t        tbl[7];
    logic [63:0] p;
    logic [15:0] q;
    int          lat;
    logic [7:0]  cv[6];
    logic [63:0] exp_q[$];
    int          cyc, last_acc, nacc, nres;
    logic        rb;

    tbl[0] = '{32'hFFFFFFFF, 32'hFFFFFFFF, 1'b0, 64'hFFFFFFFE00000001};
    tbl[1] = '{32'h80000000, 32'h80000000, 1'b1, 64'h4000000000000000};
    tbl[2] = '{32'h80000000, 32'h7FFFFFFF, 1'b1, 64'hC000000080000000};
    tbl[3] = '{32'hFFFFFFFF, 32'hFFFFFFFF, 1'b1, 64'h0000000000000001};
    tbl[4] = '{32'h00000003, 32'h00000005, 1'b0, 64'h000000000000000F};
    tbl[5] = '{32'h00000007, 32'hFFFFFFFD, 1'b1, 64'hFFFFFFFFFFFFFFEB};
    tbl[6] = '{32'h00000000, 32'hDEADBEEF, 1'b1, 64'h0000000000000000};
    cv = '{8'h00, 8'h01, 8'h7F, 8'h80, 8'hFF, 8'h81};

    iv32 = 0; or32 = 0; a32 = 0; b32 = 0; s32 = 0;
    iv8 = 0;  or8 = 0;  a8 = 0;  b8 = 0;  s8 = 0;
    rst_n = 1'b0;
    #1;
    chk("reset in_ready", 64'(ir32), 64'd1);
    chk("reset out_valid", 64'(ov32), 64'd0);
    chk("reset p", p32, 64'd0);
    chk("reset p8", 64'(p8), 64'd0);
    @(posedge clk); #1;
    rst_n = 1'b1;
    @(posedge clk); #1;

    for (int i = 0; i < 7; i++) begin
      run32(tbl[i].a, tbl[i].b, tbl[i].s, p, lat);
      chk($sformatf("table[%0d] p", i), p, tbl[i].exp);
      chk($sformatf("table[%0d] latency", i), 64'(lat), 64'd17);
    end

    // Backpressure: result held, new operands ignored.
    a32 = 32'd3; b32 = 32'd5; s32 = 1'b0; iv32 = 1'b1;
    @(posedge clk); #1;
    iv32 = 1'b0;
    lat = 0;
    while (!ov32 && lat < 100) begin @(posedge clk); #1; lat++; end
    chk("bp latency", 64'(lat), 64'd17);
    for (int i = 0; i < 6; i++) begin
      iv32 = i[0]; a32 = $urandom; b32 = $urandom; s32 = i[1];
      @(posedge clk); #1;
      chk("bp p held", p32, 64'hF);
      chk("bp in_ready", 64'(ir32), 64'd0);
      chk("bp out_valid", 64'(ov32), 64'd1);
    end
    or32 = 1'b1; iv32 = 1'b1;
    @(posedge clk); #1;
    chk("bp release out_valid", 64'(ov32), 64'd0);
    chk("bp release in_ready", 64'(ir32), 64'd1);
    iv32 = 1'b0; or32 = 1'b0;
    @(posedge clk); #1;
    chk("bp no accept", 64'(ir32), 64'd1);

    // Reset in the middle of CALC.
    a32 = 32'h12345678; b32 = 32'h9ABCDEF0; s32 = 1'b1; iv32 = 1'b1;
    @(posedge clk); #1;
    iv32 = 1'b0;
    repeat (5) begin @(posedge clk); #1; end
    rst_n = 1'b0;
    #1;
    chk("midrst out_valid", 64'(ov32), 64'd0);
    chk("midrst p", p32, 64'd0);
    chk("midrst in_ready", 64'(ir32), 64'd1);
    #3 rst_n = 1'b1;
    @(posedge clk); #1;
    chk("midrst no stale valid", 64'(ov32), 64'd0);
    run32(32'd7, 32'hFFFFFFFD, 1'b1, p, lat);
    chk("midrst next p", p, 64'hFFFFFFFFFFFFFFEB);

    // Back-to-back with both handshakes held high.
    cyc = 0; last_acc = -1; nacc = 0; nres = 0;
    a32 = $urandom; b32 = $urandom; s32 = 1'($urandom); iv32 = 1'b1; or32 = 1'b1;
    while (nres < 5 && cyc < 300) begin
      rb = ir32;
      @(posedge clk); #1;
      cyc++;
      if (rb && iv32) begin
        exp_q.push_back(ref32(a32, b32, s32));
        if (last_acc >= 0) chk("b2b spacing", 64'(cyc - last_acc), 64'd19);
        last_acc = cyc; nacc++;
        a32 = $urandom; b32 = $urandom; s32 = 1'($urandom);
        if (nacc == 5) iv32 = 1'b0;
      end
      if (ov32 && exp_q.size() > 0) begin
        chk("b2b result", p32, exp_q.pop_front());
        nres++;
      end
    end
    chk("b2b completed", 64'(nres), 64'd5);
    @(posedge clk); #1;
    iv32 = 1'b0; or32 = 1'b0;

    for (int i = 0; i < 150; i++) begin
      logic [31:0] ra, rbv;
      logic        rs;
      ra = $urandom; rbv = $urandom; rs = 1'($urandom);
      if (i < 20) ra = {ra[31], 31'(ra[3:0])};
      run32(ra, rbv, rs, p, lat);
      chk($sformatf("rand32 %h*%h s=%0d", ra, rbv, rs), p, ref32(ra, rbv, rs));
    end

    // WIDTH=8: operand corners in both modes, then random.
    for (int s = 0; s < 2; s++)
      for (int i = 0; i < 6; i++)
        for (int j = 0; j < 6; j++) begin
          run8(cv[i], cv[j], 1'(s), q, lat);
          chk($sformatf("w8 %h*%h s=%0d", cv[i], cv[j], s), 64'(q), 64'(ref8(cv[i], cv[j], 1'(s))));
          chk("w8 latency", 64'(lat), 64'd5);
        end
    for (int i = 0; i < 1500; i++) begin
      logic [7:0] ra, rbv;
      logic       rs;
      ra = 8'($urandom); rbv = 8'($urandom); rs = 1'($urandom);
      run8(ra, rbv, rs, q, lat);
      chk($sformatf("rand8 %h*%h s=%0d", ra, rbv, rs), 64'(q), 64'(ref8(ra, rbv, rs)));
    end

    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end

endmodule
